serial_alu: RTL and testbench

Parametrised bit-serial ALU for the Lab datapath. It generalises the single-bit NOR cell into a WIDTH-bit unit supporting logic, add, subtract and set-less-than. A single 1-bit slice is iterated LSB-first, one bit per clock, under a small FSM with a start/done handshake. It sits between the register-file read ports and the writeback mux, and trades latency for a minimal adder footprint.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_slice1.sv | 32 +++
 rtl/serial_alu.sv | 166 ++++++++++++++++
 tb/tb_serial_alu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encoding for the bit-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // SUB and SLT both run as a + ~b + 1 through the slice.
    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_slice1.sv
// One-bit ALU slice: logic functions plus a full-adder bit, purely combinational.
module alu_slice1
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       r,
    output logic       cout
);

    always_comb begin
        r    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_XOR: r = a ^ b;
            OP_ADD, OP_SUB, OP_SLT: begin
                r    = a ^ b ^ cin;
                cout = (a & b) | (cin & (a ^ b));
            end
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one slice iterated LSB-first over WIDTH cycles behind a start/done handshake.
module serial_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic [2:0]       op_q, op_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             slice_b;
    logic             slice_r;
    logic             slice_cout;
    logic             msb_ovf;
    logic [WIDTH-1:0] res_cat;
    logic [WIDTH-1:0] fin_res;
    logic             fin_carry;
    logic             fin_ovf;

    alu_slice1 u_slice (
        .a   (a_sh_q[0]),
        .b   (slice_b),
        .cin (cy_q),
        .op  (op_q),
        .r   (slice_r),
        .cout(slice_cout)
    );

    // Final-bit view: only meaningful on the last RUN cycle, where cy_q is the MSB carry-in.
    always_comb begin
        slice_b   = b_sh_q[0] ^ is_sub(op_q);
        msb_ovf   = cy_q ^ slice_cout;
        res_cat   = {slice_r, res_sh_q};
        fin_res   = res_cat;
        fin_carry = 1'b0;
        fin_ovf   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                fin_carry = slice_cout;
                fin_ovf   = msb_ovf;
            end
            OP_SLT:  fin_res = {{(WIDTH-1){1'b0}}, slice_r ^ msb_ovf};
            OP_RSVD: fin_res = '0;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_sh_d   = res_sh_q;
        op_d       = op_q;
        cy_d       = cy_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    cy_d    = is_sub(op);
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_cat[WIDTH-1:1];
                cy_d     = slice_cout;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    state_d    = StDone;
                    done_d     = 1'b1;
                    result_d   = fin_res;
                    zero_d     = ~|fin_res;
                    carry_d    = fin_carry;
                    overflow_d = fin_ovf;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            op_q       <= '0;
            cy_q       <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_sh_q   <= res_sh_d;
            op_q       <= op_d;
            cy_q       <= cy_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench: three serial_alu instances (WIDTH 8, 4, 16) against an arithmetic model.
module tb_serial_alu;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [3];
    logic [2:0]  op_s    [3];
    logic [31:0] a_s     [3];
    logic [31:0] b_s     [3];

    wire  [2:0]  busy_o, done_o, zero_o, carry_o, ovf_o;
    logic [7:0]  r0;
    logic [3:0]  r1;
    logic [15:0] r2;
    logic [31:0] res_o   [3];
    logic [31:0] last_exp [3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        res_o[0] = 32'(r0);
        res_o[1] = 32'(r1);
        res_o[2] = 32'(r2);
    end

    serial_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]),
        .busy(busy_o[0]), .done(done_o[0]), .result(r0),
        .zero(zero_o[0]), .carry(carry_o[0]), .overflow(ovf_o[0])
    );

    serial_alu #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]),
        .a(a_s[1][3:0]), .b(b_s[1][3:0]),
        .busy(busy_o[1]), .done(done_o[1]), .result(r1),
        .zero(zero_o[1]), .carry(carry_o[1]), .overflow(ovf_o[1])
    );

    serial_alu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start_s[2]), .op(op_s[2]),
        .a(a_s[2][15:0]), .b(b_s[2][15:0]),
        .busy(busy_o[2]), .done(done_o[2]), .result(r2),
        .zero(zero_o[2]), .carry(carry_o[2]), .overflow(ovf_o[2])
    );

    function automatic int wof(input int k);
        return (k == 0) ? 8 : (k == 1) ? 4 : 16;
    endfunction

    // Reference: integer arithmetic on unsigned/signed interpretations of the operands.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & mask;
        longint ub   = longint'(b) & mask;
        longint sa   = (ua >= half) ? ua - (mask + 1) : ua;
        longint sb   = (ub >= half) ? ub - (mask + 1) : ub;
        longint r    = 0;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            3'd0: r = ua & ub;
            3'd1: r = ua | ub;
            3'd2: r = ~(ua | ub) & mask;
            3'd3: r = ua ^ ub;
            3'd4: begin
                r   = (ua + ub) & mask;
                e.c = (ua + ub) > mask;
                e.v = ((sa + sb) >= half) || ((sa + sb) < -half);
            end
            3'd5: begin
                r   = (ua - ub) & mask;
                e.c = ua >= ub;
                e.v = ((sa - sb) >= half) || ((sa - sb) < -half);
            end
            3'd6: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        e.res = 32'(r);
        e.z   = (r == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Issue one op on DUT k from an IDLE cycle; checks handshake timing and final outputs.
    task automatic do_op(input int k, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e, input string tag);
        int w;
        int lat;
        w = wof(k);
        start_s[k] = 1'b1;
        op_s[k]    = op;
        a_s[k]     = a;
        b_s[k]     = b;
        @(posedge clk); #1;
        chk({tag, " busy_rise"}, 32'(busy_o[k]), 32'd1);
        chk({tag, " result_held"}, res_o[k], last_exp[k]);
        start_s[k] = 1'b0;
        op_s[k]    = 3'($urandom);
        a_s[k]     = $urandom;
        b_s[k]     = $urandom;
        lat = 0;
        while (!done_o[k] && lat < w + 4) begin
            @(posedge clk); #1;
            lat++;
            if (!done_o[k]) a_s[k] = $urandom;
        end
        chk({tag, " done_latency"}, 32'(lat), 32'(w));
        chk({tag, " result"}, res_o[k], e.res);
        chk({tag, " flags_zcv"}, {29'd0, zero_o[k], carry_o[k], ovf_o[k]}, {29'd0, e.z, e.c, e.v});
        @(posedge clk); #1;
        chk({tag, " done_busy_fall"}, {30'd0, done_o[k], busy_o[k]}, 32'd0);
        last_exp[k] = e.res;
    endtask

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{3'd4, 32'h7F, 32'h01, '{32'h80, 1'b0, 1'b0, 1'b1}};
        tbl[1]  = '{3'd5, 32'h05, 32'h05, '{32'h00, 1'b1, 1'b1, 1'b0}};
        tbl[2]  = '{3'd5, 32'h03, 32'h05, '{32'hFE, 1'b0, 1'b0, 1'b0}};
        tbl[3]  = '{3'd2, 32'hF0, 32'h0F, '{32'h00, 1'b1, 1'b0, 1'b0}};
        tbl[4]  = '{3'd2, 32'h00, 32'h00, '{32'hFF, 1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{3'd6, 32'hFE, 32'h01, '{32'h01, 1'b0, 1'b0, 1'b0}};
        tbl[6]  = '{3'd6, 32'h01, 32'hFE, '{32'h00, 1'b1, 1'b0, 1'b0}};
        tbl[7]  = '{3'd0, 32'hCC, 32'hAA, '{32'h88, 1'b0, 1'b0, 1'b0}};
        tbl[8]  = '{3'd1, 32'hCC, 32'hAA, '{32'hEE, 1'b0, 1'b0, 1'b0}};
        tbl[9]  = '{3'd3, 32'hCC, 32'hAA, '{32'h66, 1'b0, 1'b0, 1'b0}};
        tbl[10] = '{3'd7, 32'hFF, 32'hFF, '{32'h00, 1'b1, 1'b0, 1'b0}};
        tbl[11] = '{3'd4, 32'hFF, 32'h01, '{32'h00, 1'b1, 1'b1, 1'b0}};
        tbl[12] = '{3'd5, 32'h80, 32'h01, '{32'h7F, 1'b0, 1'b1, 1'b1}};
        tbl[13] = '{3'd6, 32'h80, 32'h7F, '{32'h01, 1'b0, 1'b0, 1'b0}};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_s[k]  = 1'b0;
            op_s[k]     = 3'd0;
            a_s[k]      = 32'd0;
            b_s[k]      = 32'd0;
            last_exp[k] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("w%0d reset_outputs", wof(k)),
                {res_o[k][26:0], busy_o[k], done_o[k], zero_o[k], carry_o[k], ovf_o[k]}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed set on each width; WIDTH=8 uses the hand-computed table values.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 14; i++) begin
                exp_t e;
                e = (k == 0) ? tbl[i].e : model(wof(k), tbl[i].op, tbl[i].a, tbl[i].b);
                do_op(k, tbl[i].op, tbl[i].a, tbl[i].b, e, $sformatf("w%0d vec%0d", wof(k), i));
            end

            // Abort mid-RUN with an asynchronous reset after 4 bits.
            start_s[k] = 1'b1;
            op_s[k]    = 3'd4;
            a_s[k]     = 32'h3C;
            b_s[k]     = 32'h41;
            @(posedge clk); #1;
            start_s[k] = 1'b0;
            repeat (4) @(posedge clk);
            #3 rst = 1'b1;
            #1;
            chk($sformatf("w%0d midrun_rst result", wof(k)), res_o[k], 32'd0);
            chk($sformatf("w%0d midrun_rst flags", wof(k)),
                {27'd0, busy_o[k], done_o[k], zero_o[k], carry_o[k], ovf_o[k]}, 32'd0);
            #1 rst = 1'b0;
            for (int j = 0; j < 3; j++) last_exp[j] = 32'd0;
            @(posedge clk); #1;
            do_op(k, 3'd4, 32'h10, 32'h20, model(wof(k), 3'd4, 32'h10, 32'h20),
                  $sformatf("w%0d add_after_rst", wof(k)));
        end

        // start held high with operands churning: only accept-edge operands matter.
        begin
            int w;
            int d1;
            int d2;
            int nd;
            logic [31:0] rr1;
            logic [31:0] rr2;
            w  = 8;
            d1 = -1;
            d2 = -1;
            nd = 0;
            rr1 = '0;
            rr2 = '0;
            start_s[0] = 1'b1;
            op_s[0]    = 3'd4;
            a_s[0]     = 32'h11;
            b_s[0]     = 32'h22;
            @(posedge clk); #1;
            for (int n = 1; n <= 2 * w + 4; n++) begin
                if (n == w + 2) begin
                    op_s[0] = 3'd4;
                    a_s[0]  = 32'h05;
                    b_s[0]  = 32'h06;
                end else begin
                    op_s[0] = 3'($urandom);
                    a_s[0]  = $urandom;
                    b_s[0]  = $urandom;
                end
                if (n >= 2 * w + 3) start_s[0] = 1'b0;
                @(posedge clk); #1;
                if (done_o[0]) begin
                    nd++;
                    if (d1 < 0) begin d1 = n; rr1 = res_o[0]; end
                    else begin d2 = n; rr2 = res_o[0]; end
                end
            end
            start_s[0] = 1'b0;
            chk("hold done_count", 32'(nd), 32'd2);
            chk("hold done1_edge", 32'(d1), 32'(w));
            chk("hold done2_edge", 32'(d2), 32'(2 * w + 2));
            chk("hold result1", rr1, 32'h33);
            chk("hold result2", rr2, 32'h0B);
            last_exp[0] = 32'h0B;
            @(posedge clk); #1;
        end

        // Randomised ops against the model on every width.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [2:0]  rop;
                logic [31:0] ra;
                logic [31:0] rb;
                rop = 3'($urandom_range(0, 7));
                ra  = $urandom;
                rb  = $urandom;
                do_op(k, rop, ra, rb, model(wof(k), rop, ra, rb),
                      $sformatf("w%0d rnd%0d op%0d", wof(k), i, rop));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
